// File: rtl/dot_feeder_pkg.sv
// dot_feeder_pkg: constants and the state type shared by the dot_feeder files.
// BIT_LENGTH/DATA_N set the slice geometry. IN_LENGTH/HID_LENGTH set the layer
// size. CHUNKS and TOTAL are derived from them. The package also holds the
// sequencer state enum.
package dot_feeder_pkg;

    localparam int BIT_LENGTH = 16;
    localparam int DATA_N     = 6;
    localparam int IN_LENGTH  = 24;
    localparam int HID_LENGTH = 24;
    localparam int ADDR_W     = 7;
    localparam int DRAIN_MAX  = 16;

    localparam int CHUNKS = IN_LENGTH / DATA_N;
    localparam int TOTAL  = HID_LENGTH * CHUNKS;

    localparam int VEC_AW = $clog2(IN_LENGTH);
    localparam int C_W    = $clog2(CHUNKS);
    localparam int K_W    = $clog2(TOTAL);
    localparam int D_W    = $clog2(DRAIN_MAX);

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        PREFETCH = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        HOLD     = 3'd4,
        CLEAR    = 3'd5
    } state_t;

    // Chunk index c = k mod CHUNKS for stream cycle k.
    function automatic logic [C_W-1:0] chunk_of(input logic [K_W-1:0] k);
        return C_W'(k % K_W'(CHUNKS));
    endfunction

endpackage

// File: rtl/dot_feeder_vecbuf.sv
// dot_feeder_vecbuf: IN_LENGTH x BIT_LENGTH register file holding the input vector.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset (clears contents)
//   we, waddr, wdata  serial write port, one element per cycle
//   rd_chunk          chunk index c of the slice to read
//   rd_slice          combinational read: lane i = x[DATA_N*c + i]
module dot_feeder_vecbuf
    import dot_feeder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [VEC_AW-1:0]            waddr,
    input  logic [BIT_LENGTH-1:0]        wdata,
    input  logic [C_W-1:0]               rd_chunk,
    output logic [DATA_N*BIT_LENGTH-1:0] rd_slice
);

    logic [BIT_LENGTH-1:0] mem_r [IN_LENGTH];

    // Element storage: cleared on reset, written one element per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < IN_LENGTH; e++) begin
                mem_r[e] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < DATA_N; i++) begin : g_lane
        logic [VEC_AW-1:0] idx_s;
        assign idx_s = VEC_AW'(rd_chunk) * VEC_AW'(DATA_N) + VEC_AW'(i);
        assign rd_slice[i*BIT_LENGTH +: BIT_LENGTH] = mem_r[idx_s];
    end

endmodule

// File: rtl/dot_feeder.sv
// dot_feeder: sequencer in front of the 6-lane dot-product stage.
// It loads one input vector serially and prefetches weight words. It then
// streams aligned data/weight slices with run high, drains until dot_valid,
// pulses res_take, and clears the dot stage.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready/in_data serial input vector (element 0 first)
//   w_en/w_addr/w_rdata      synchronous weight memory (1-cycle read latency)
//   run/dot_data/dot_weight  dot stage drive
//   dot_valid                dot stage results ready
//   res_take                 1-cycle capture pulse for the consumer
//   busy                     high outside LOAD
//   err_timeout              sticky drain timeout flag
module dot_feeder
    import dot_feeder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_LENGTH-1:0]        in_data,
    output logic                         w_en,
    output logic [ADDR_W-1:0]            w_addr,
    input  logic [DATA_N*BIT_LENGTH-1:0] w_rdata,
    output logic                         run,
    output logic [DATA_N*BIT_LENGTH-1:0] dot_data,
    output logic [DATA_N*BIT_LENGTH-1:0] dot_weight,
    input  logic                         dot_valid,
    output logic                         res_take,
    output logic                         busy,
    output logic                         err_timeout
);

    state_t                        state_r, state_s;
    logic [VEC_AW-1:0]             wcnt_r, wcnt_s;
    logic [K_W-1:0]                k_r, k_s;
    logic [D_W-1:0]                dcnt_r, dcnt_s;
    logic                          err_r, err_s;
    logic                          we_s;
    logic                          accept_s;

    logic                          in_ready_r, busy_r, run_r, w_en_r, stream_r, res_take_r;
    logic [ADDR_W-1:0]             w_addr_r;
    logic [DATA_N*BIT_LENGTH-1:0]  dot_data_r;

    logic                          run_s, w_en_s, stream_s;
    logic [ADDR_W-1:0]             w_addr_s;
    logic [DATA_N*BIT_LENGTH-1:0]  dot_data_s;
    logic [DATA_N*BIT_LENGTH-1:0]  slice_s;
    logic [C_W-1:0]                rd_chunk_s;

    assign accept_s = in_valid && (state_r == LOAD);

    dot_feeder_vecbuf u_vecbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we_s),
        .waddr    (wcnt_r),
        .wdata    (in_data),
        .rd_chunk (rd_chunk_s),
        .rd_slice (slice_s)
    );

    // Next-state, counters and sticky error.
    always_comb begin
        state_s = state_r;
        wcnt_s  = wcnt_r;
        k_s     = k_r;
        dcnt_s  = dcnt_r;
        err_s   = err_r;
        we_s    = 1'b0;
        case (state_r)
            LOAD: begin
                if (accept_s) begin
                    we_s = 1'b1;
                    if (wcnt_r == VEC_AW'(IN_LENGTH - 1)) begin
                        state_s = PREFETCH;
                        wcnt_s  = '0;
                    end else begin
                        wcnt_s = wcnt_r + VEC_AW'(1);
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            PREFETCH: begin
                state_s = STREAM;
                k_s     = '0;
            end
            STREAM: begin
                if (k_r == K_W'(TOTAL - 1)) begin
                    state_s = DRAIN;
                    dcnt_s  = '0;
                end else begin
                    k_s = k_r + K_W'(1);
                end
            end
            DRAIN: begin
                if (dot_valid) begin
                    state_s = HOLD;
                end else if (dcnt_r == D_W'(DRAIN_MAX - 1)) begin
                    state_s = CLEAR;
                    err_s   = 1'b1;
                end else begin
                    dcnt_s = dcnt_r + D_W'(1);
                end
            end
            HOLD: begin
                state_s = CLEAR;
            end
            CLEAR: begin
                state_s = LOAD;
                wcnt_s  = '0;
            end
            default: begin
                state_s = LOAD;
                wcnt_s  = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so that
    // the registered copies line up with the memory's read register.
    always_comb begin
        run_s      = 1'b0;
        w_en_s     = 1'b0;
        w_addr_s   = '0;
        stream_s   = 1'b0;
        dot_data_s = '0;
        rd_chunk_s = chunk_of(k_s);
        if (state_s == PREFETCH) begin
            w_en_s = 1'b1;
        end else if (state_s == STREAM) begin
            run_s      = 1'b1;
            stream_s   = 1'b1;
            dot_data_s = slice_s;
            if (k_s != K_W'(TOTAL - 1)) begin
                w_en_s   = 1'b1;
                w_addr_s = ADDR_W'(k_s) + ADDR_W'(1);
            end else begin
                w_en_s = 1'b0;
            end
        end else if ((state_s == DRAIN) || (state_s == HOLD)) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
            wcnt_r  <= '0;
            k_r     <= '0;
            dcnt_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            wcnt_r  <= wcnt_s;
            k_r     <= k_s;
            dcnt_r  <= dcnt_s;
            err_r   <= err_s;
        end
    end

    // Registered outputs; run, dot_data and the weight gate change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            run_r      <= 1'b0;
            w_en_r     <= 1'b0;
            w_addr_r   <= '0;
            stream_r   <= 1'b0;
            dot_data_r <= '0;
            res_take_r <= 1'b0;
        end else begin
            in_ready_r <= (state_s == LOAD);
            busy_r     <= (state_s != LOAD);
            run_r      <= run_s;
            w_en_r     <= w_en_s;
            w_addr_r   <= w_addr_s;
            stream_r   <= stream_s;
            dot_data_r <= dot_data_s;
            res_take_r <= (state_s == HOLD);
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign run         = run_r;
    assign w_en        = w_en_r;
    assign w_addr      = w_addr_r;
    assign dot_data    = dot_data_r;
    // The memory read register already holds word k during stream cycle k.
    assign dot_weight  = stream_r ? w_rdata : '0;
    assign res_take    = res_take_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_dot_feeder.sv
module tb_dot_feeder;

    localparam int BL    = 16;
    localparam int LANES = 6;
    localparam int IN_N  = 24;
    localparam int HID_N = 24;
    localparam int CH    = IN_N / LANES;
    localparam int TOT   = HID_N * CH;
    localparam int DMAX  = 16;
    localparam int DV_AT = 101;

    logic              clk, rst_n, in_valid, in_ready, w_en, run, dot_valid;
    logic              res_take, busy, err_timeout;
    logic [BL-1:0]     in_data;
    logic [6:0]        w_addr;
    logic [95:0]       w_rdata, dot_data, dot_weight;

    dot_feeder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_en(w_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .run(run), .dot_data(dot_data), .dot_weight(dot_weight),
        .dot_valid(dot_valid), .res_take(res_take), .busy(busy),
        .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic [95:0] d;
        logic [95:0] w;
        logic        en;
        logic [6:0]  a;
    } slice_t;

    slice_t      exp_q[$];
    int          exp_start_q[$];
    int          exp_len_q[$];
    int          exp_take_q[$];

    logic [15:0] vec [IN_N];
    logic [95:0] wmem [128];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          dv_enable = 1'b1;
    int          dot_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous weight memory, one-cycle read latency.
    always @(posedge clk) begin
        if (w_en) w_rdata <= wmem[w_addr];
    end

    // Dot stage: registers dot_valid after run-cycle DV_AT, holds it while run stays high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dot_cnt   <= 0;
            dot_valid <= 1'b0;
        end else if (run) begin
            dot_cnt <= dot_cnt + 1;
            if (dv_enable && dot_cnt == DV_AT) dot_valid <= 1'b1;
        end else begin
            dot_cnt   <= 0;
            dot_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT drives a run cycle.
    int     mon_idx = 0;
    int     mon_takes = 0;
    int     mon_take_at = -1;
    bit     mon_prev = 1'b0;
    slice_t mon_e;
    int     mon_v;
    int     mon_t;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete(); exp_start_q.delete(); exp_len_q.delete(); exp_take_q.delete();
            mon_idx = 0; mon_takes = 0; mon_take_at = -1; mon_prev = 1'b0;
        end else begin
            if (run) begin
                if (!mon_prev) begin
                    if (exp_start_q.size() == 0) chk("run_start_unexpected", 96'(1), 96'(0));
                    else begin
                        mon_v = exp_start_q.pop_front();
                        chk("run_start_cycle", 96'(cyc), 96'(mon_v));
                    end
                end
                if (mon_idx < TOT) begin
                    if (exp_q.size() == 0) chk("slice_unexpected", 96'(1), 96'(0));
                    else begin
                        mon_e = exp_q.pop_front();
                        chk($sformatf("dot_data_k%0d", mon_idx), dot_data, mon_e.d);
                        chk($sformatf("dot_weight_k%0d", mon_idx), dot_weight, mon_e.w);
                        chk($sformatf("w_en_k%0d", mon_idx), 96'(w_en), 96'(mon_e.en));
                        if (mon_e.en) chk($sformatf("w_addr_k%0d", mon_idx), 96'(w_addr), 96'(mon_e.a));
                    end
                end else begin
                    chk("drain_data_zero", dot_data, 96'(0));
                    chk("drain_weight_zero", dot_weight, 96'(0));
                end
                if (res_take) begin
                    mon_takes++;
                    mon_take_at = mon_idx;
                end
                mon_idx++;
            end else begin
                if (mon_prev) begin
                    if (exp_len_q.size() == 0) chk("burst_unexpected", 96'(1), 96'(0));
                    else begin
                        mon_v = exp_len_q.pop_front();
                        mon_t = exp_take_q.pop_front();
                        chk("run_burst_len", 96'(mon_idx), 96'(mon_v));
                        chk("res_take_count", 96'(mon_takes), 96'((mon_t >= 0) ? 1 : 0));
                        if (mon_t >= 0) chk("res_take_pos", 96'(mon_take_at), 96'(mon_t));
                        chk("clear_busy", 96'(busy), 96'(1));
                        chk("clear_in_ready", 96'(in_ready), 96'(0));
                    end
                    mon_idx = 0; mon_takes = 0; mon_take_at = -1;
                end
                chk("idle_data_zero", dot_data, 96'(0));
                chk("idle_res_take", 96'(res_take), 96'(0));
            end
            mon_prev = run;
        end
    end

    // Drive one vector from vec[]; on the last accept push the expected stream.
    task automatic load_vec(input bit toggle, input bit holdoff);
        int     i = 0;
        int     guard = 0;
        bit     v;
        slice_t e;
        while (i < IN_N && guard < 2000) begin
            @(negedge clk);
            guard++;
            v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_data  = vec[i];
            if (v && in_ready) begin
                i++;
                if (i == IN_N) exp_start_q.push_back(cyc + 2);
            end
        end
        if (i < IN_N) begin
            chk("load_timeout", 96'(i), 96'(IN_N));
        end else begin
            for (int k = 0; k < TOT; k++) begin
                for (int l = 0; l < LANES; l++) e.d[l*BL +: BL] = vec[(k % CH) * LANES + l];
                e.w  = wmem[k];
                e.en = (k + 1 < TOT);
                e.a  = 7'(k + 1);
                exp_q.push_back(e);
            end
            exp_len_q.push_back(dv_enable ? TOT + 8 : TOT + DMAX);
            exp_take_q.push_back(dv_enable ? TOT + 7 : -1);
        end
        if (holdoff) begin
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 16'hDEAD;
                chk("word25_held_off", 96'(in_ready), 96'(0));
            end
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(exp_len_q.size() == 0 && in_ready && !run) && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_reached", 96'(guard < 600), 96'(1));
    endtask

    task automatic set_ramp();
        for (int i = 0; i < IN_N; i++) vec[i] = 16'(i + 1);
        for (int k = 0; k < 128; k++) wmem[k] = (k < TOT) ? {6{16'h0001}} : 96'(0);
    endtask

    task automatic set_random_vec();
        for (int i = 0; i < IN_N; i++) vec[i] = 16'($urandom);
    endtask

    task automatic set_random_mem();
        for (int k = 0; k < 128; k++) wmem[k] = {$urandom, $urandom, $urandom};
    endtask

    initial begin
        int g;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; w_rdata = '0;
        set_ramp();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_run", 96'(run), 96'(0));
        chk("rst_w_en", 96'(w_en), 96'(0));
        chk("rst_w_addr", 96'(w_addr), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_res_take", 96'(res_take), 96'(0));
        chk("rst_err", 96'(err_timeout), 96'(0));
        chk("rst_dot_data", dot_data, 96'(0));
        chk("rst_dot_weight", dot_weight, 96'(0));
        #3 rst_n = 1'b1;

        // Ramp vector against all-ones weights.
        load_vec(1'b0, 1'b0);
        wait_idle();
        chk("err_after_normal", 96'(err_timeout), 96'(0));

        // Random data and weights, 50% valid toggling, 25th word held off.
        set_random_vec(); set_random_mem();
        load_vec(1'b1, 1'b1);
        wait_idle();

        // Back-to-back vectors.
        set_random_vec();
        load_vec(1'b0, 1'b0);
        set_random_vec();
        load_vec(1'b0, 1'b0);
        wait_idle();

        // Drain timeout: dot_valid never arrives.
        dv_enable = 1'b0;
        set_random_vec();
        load_vec(1'b0, 1'b0);
        wait_idle();
        chk("err_set_on_timeout", 96'(err_timeout), 96'(1));
        dv_enable = 1'b1;
        set_random_vec();
        load_vec(1'b1, 1'b0);
        wait_idle();
        chk("err_sticky", 96'(err_timeout), 96'(1));

        // Reset in the middle of the stream at k=40.
        set_ramp();
        load_vec(1'b0, 1'b0);
        g = 0;
        while (!run && g < 50) begin @(negedge clk); g++; end
        chk("run_seen_before_abort", 96'(run), 96'(1));
        repeat (40) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_run", 96'(run), 96'(0));
        chk("abort_w_en", 96'(w_en), 96'(0));
        chk("abort_busy", 96'(busy), 96'(0));
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_in_ready", 96'(in_ready), 96'(1));
        chk("after_reset_err", 96'(err_timeout), 96'(0));
        load_vec(1'b0, 1'b0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
